// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module display_scan_ctrl #(
  parameter int DIGIT_TICKS = 25000,
  parameter int GUARD_TICKS = 250,
  parameter int BLINK_TICKS = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        bad_bcd
);

  localparam int DW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DW-1:0] C_DIG_LAST = DW'(DIGIT_TICKS - 1);
  localparam logic [DW-1:0] C_GUARD    = DW'(GUARD_TICKS);
  localparam logic [BW-1:0] C_BLK_LAST = BW'(BLINK_TICKS - 1);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_sel;
  logic [15:0]   r_shadow;
  logic [BW-1:0] r_blink;
  logic          r_phase;
  logic [3:0]    r_an;
  logic [3:0]    r_bcd;
  logic          r_bad;

  logic          w_dwell_tc;
  logic [DW-1:0] w_dwell_nxt;
  logic [1:0]    w_sel_nxt;
  logic [15:0]   w_shadow_nxt;
  logic          w_blink_tc;
  logic [BW-1:0] w_blink_nxt;
  logic          w_phase_nxt;
  logic [3:0]    w_nibble;
  logic          w_valid;
  logic          w_blanked;
  logic          w_lz_blank;
  logic          w_lit;
  logic [3:0]    w_an_nxt;
  logic [3:0]    w_bcd_nxt;

  // Outputs are computed from next-state values so an, bcd_out and digit_sel
  // all change on the same edge as the dwell counter they describe.
  always_comb begin
    w_dwell_tc   = (r_dwell == C_DIG_LAST);
    w_dwell_nxt  = w_dwell_tc ? '0 : r_dwell + 1'b1;
    w_sel_nxt    = w_dwell_tc ? r_sel + 2'd1 : r_sel;
    w_shadow_nxt = (w_dwell_tc && (r_sel == 2'd3)) ? digits : r_shadow;

    w_blink_tc   = (r_blink == C_BLK_LAST);
    w_blink_nxt  = w_blink_tc ? '0 : r_blink + 1'b1;
    w_phase_nxt  = r_phase ^ w_blink_tc;

    w_nibble     = w_shadow_nxt[{w_sel_nxt, 2'b00} +: 4];
    w_valid      = (w_nibble <= 4'd9);
    w_blanked    = w_phase_nxt & blink_mask[w_sel_nxt];
`ifdef LEADING_ZERO_BLANK_EN
    w_lz_blank   = (w_sel_nxt == 2'd3) && (w_shadow_nxt[15:12] == 4'd0);
`else
    w_lz_blank   = 1'b0;
`endif
    w_lit        = en && w_valid && !w_blanked && !w_lz_blank &&
                   (w_dwell_nxt >= C_GUARD);

    w_an_nxt     = 4'b1111;
    if (w_lit) begin
      w_an_nxt[w_sel_nxt] = 1'b0;
    end
    w_bcd_nxt    = w_valid ? w_nibble : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dwell  <= '0;
      r_sel    <= 2'd0;
      r_shadow <= 16'h0000;
      r_blink  <= '0;
      r_phase  <= 1'b0;
      r_an     <= 4'b1111;
      r_bcd    <= 4'd0;
      r_bad    <= 1'b0;
    end else begin
      r_dwell  <= w_dwell_nxt;
      r_sel    <= w_sel_nxt;
      r_shadow <= w_shadow_nxt;
      r_blink  <= w_blink_nxt;
      r_phase  <= w_phase_nxt;
      r_an     <= w_an_nxt;
      r_bcd    <= w_bcd_nxt;
      r_bad    <= r_bad | ~w_valid;
    end
  end

  assign bcd_out   = r_bcd;
  assign an        = r_an;
  assign digit_sel = r_sel;
  assign bad_bcd   = r_bad;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-count reference model pushes
// expected outputs, a monitor pops and compares one entry per clock.
module tb_display_scan_ctrl;

  localparam int D = 4;
  localparam int G = 1;
  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        bad_bcd;

  display_scan_ctrl #(
    .DIGIT_TICKS(D),
    .GUARD_TICKS(G),
    .BLINK_TICKS(B)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .digits(digits),
    .blink_mask(blink_mask),
    .bcd_out(bcd_out),
    .an(an),
    .digit_sel(digit_sel),
    .bad_bcd(bad_bcd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] an;
    logic [1:0] sel;
    logic       bad;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad_cnt = 0;

  // Reference state: edges since reset, captured frame, sticky error.
  int          m_n = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic        m_bad = 1'b0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected outputs after the coming edge, from the inputs presented to it.
  task automatic model_step();
    exp_t e;
    int s, dw, ph;
    logic [3:0] nib;
    logic valid, lit;
    if (!rst_n) begin
      m_n = 0;
      m_shadow = 16'h0000;
      m_bad = 1'b0;
      e.bcd = 4'd0;
      e.an = 4'hF;
      e.sel = 2'd0;
      e.bad = 1'b0;
    end else begin
      if (m_n % (4 * D) == 4 * D - 1) m_shadow = digits;
      m_n++;
      s  = (m_n / D) % 4;
      dw = m_n % D;
      ph = (m_n / B) % 2;
      nib = 4'((m_shadow >> (4 * s)) & 16'h000F);
      valid = (nib < 4'd10);
      if (!valid) m_bad = 1'b1;
      lit = en && valid && (dw >= G) && !(ph == 1 && blink_mask[s]);
`ifdef LEADING_ZERO_BLANK_EN
      if (s == 3 && m_shadow[15:12] == 4'd0) lit = 1'b0;
`endif
      e.bcd = valid ? nib : 4'd0;
      e.an  = lit ? ~(4'b0001 << s) : 4'hF;
      e.sel = 2'(s);
      e.bad = m_bad;
    end
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic e_in, input logic [15:0] d,
                       input logic [3:0] m);
    @(negedge clk);
    rst_n = r;
    en = e_in;
    digits = d;
    blink_mask = m;
    model_step();
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 39) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("bcd_out", int'(bcd_out), int'(e.bcd));
      check("an", int'(an), int'(e.an));
      check("digit_sel", int'(digit_sel), int'(e.sel));
      check("bad_bcd", int'(bad_bcd), int'(e.bad));
    end
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  m;
    logic        r, e_in;

    repeat (3) drive(1'b0, 1'b1, 16'h1234, 4'h0);
    repeat (120) drive(1'b1, 1'b1, 16'h1234, 4'h0);
    // Switch digits mid-frame, then run a leading-zero frame set.
    while (digit_sel != 2'd1) drive(1'b1, 1'b1, 16'h1234, 4'h0);
    repeat (60) drive(1'b1, 1'b1, 16'h0959, 4'h0);
    repeat (140) drive(1'b1, 1'b1, 16'h1234, 4'b0011);
    repeat (40) drive(1'b1, 1'b1, 16'h12A4, 4'h0);
    repeat (40) drive(1'b1, 1'b1, 16'h1234, 4'h0);
    repeat (2) drive(1'b0, 1'b1, 16'h1234, 4'h0);
    repeat (30) drive(1'b1, 1'b1, 16'h1234, 4'h0);
    repeat (10) drive(1'b1, 1'b0, 16'h1234, 4'h0);
    repeat (20) drive(1'b1, 1'b1, 16'h1234, 4'h0);
    repeat (6) drive(1'b1, 1'b1, 16'h1234, 4'h0);
    drive(1'b0, 1'b1, 16'h1234, 4'h0);

    d = 16'h1234;
    m = 4'h0;
    for (int k = 0; k < 2000; k++) begin
      r = ($urandom_range(0, 299) != 0);
      e_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) d = rand_digits();
      if ($urandom_range(0, 49) == 0) m = 4'($urandom_range(0, 15));
      drive(r, e_in, d, m);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
